// File: rtl/ctrl_decode_stage.sv
// Registered MIPS control decoder with valid/ready flow control, flush,
// multi-cycle MULT/DIV busy sequencing and SYSCALL halt/resume.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_RUN     | accepting instructions when the output slot is free
// ST_MD_WAIT | MULT/DIV issued, counting down the multiply/divide latency
// ST_HALT    | SYSCALL accepted, waiting for a resume pulse
module ctrl_decode_stage #(
  parameter int unsigned MD_LATENCY      = 4,
  parameter bit          ENABLE_MULDIV   = 1'b1,
  parameter bit          HALT_ON_SYSCALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  input  logic        resume,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        JalSrc,
  output logic [2:0]  AluOp,
  output logic [1:0]  AluSrc,
  output logic [1:0]  Branch,
  output logic [1:0]  Jump,
  output logic [1:0]  hilo_sel,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        syscall,
  output logic        illegal,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_src;
    logic [1:0] branch;
    logic [1:0] jump;
    logic       jal_src;
    logic [1:0] hilo_sel;
    logic       md_start;
    logic [1:0] md_op;
    logic       syscall;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_DIVU    = 6'h1B;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  ctrl_t      bundle_q, bundle_d;
  logic       out_valid_q, out_valid_d;
  logic       ready_en_q, ready_en_d;

  ctrl_t      dec;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       accept;
  logic       unused_instr_bits;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: begin
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
          end
          F_AND, F_SUB, F_OR, F_NOR, F_SLT, F_SLTU: begin
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
            case (funct)
              F_AND:   dec.alu_op = 3'b110;
              F_SUB:   dec.alu_op = 3'b010;
              F_OR:    dec.alu_op = 3'b111;
              default: dec.alu_op = 3'b100;
            endcase
          end
          F_SLL, F_SRL, F_SRA: begin
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = 3'b100;
            dec.alu_src   = 2'b11;
          end
          F_JR:      dec.jump    = 2'b01;
          F_SYSCALL: dec.syscall = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            if (ENABLE_MULDIV) begin
              dec.md_start = 1'b1;
              dec.md_op    = funct[1:0];
            end else begin
              dec.illegal = 1'b1;
            end
          end
          F_MFHI, F_MFLO: begin
            if (ENABLE_MULDIV) begin
              dec.reg_dst   = 1'b1;
              dec.reg_write = 1'b1;
              dec.hilo_sel  = (funct == F_MFHI) ? 2'b01 : 2'b10;
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 2'b01;
        case (opcode)
          OP_ANDI: dec.alu_op = 3'b110;
          OP_ORI:  dec.alu_op = 3'b111;
          OP_SLTI: dec.alu_op = 3'b100;
          default: dec.alu_op = 3'b000;
        endcase
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 2'b01;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 2'b01;
      end
      OP_BEQ: dec.branch = 2'b01;
      OP_BNE: dec.branch = 2'b10;
      OP_J:   dec.jump   = 2'b11;
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 2'b10;
        dec.jal_src   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // ready_en_q keeps in_ready low while reset is held and until the first edge after release
  assign in_ready = ready_en_q && (state_q == ST_RUN) && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    ready_en_d  = 1'b1;
    if (flush) begin
      bundle_d    = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      bundle_d    = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      bundle_d    = '0;
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (accept && dec.md_start) begin
          state_d = ST_MD_WAIT;
          cnt_d   = MD_LOAD;
        end else if (accept && dec.syscall && HALT_ON_SYSCALL) begin
          state_d = ST_HALT;
        end
      end
      ST_MD_WAIT: begin
        if (flush) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      ready_en_q  <= ready_en_d;
    end
  end

  assign out_valid = out_valid_q;
  assign RegDst    = bundle_q.reg_dst;
  assign RegWrite  = bundle_q.reg_write;
  assign AluOp     = bundle_q.alu_op;
  assign MemRead   = bundle_q.mem_read;
  assign MemWrite  = bundle_q.mem_write;
  assign MemtoReg  = bundle_q.mem_to_reg;
  assign AluSrc    = bundle_q.alu_src;
  assign Branch    = bundle_q.branch;
  assign Jump      = bundle_q.jump;
  assign JalSrc    = bundle_q.jal_src;
  assign hilo_sel  = bundle_q.hilo_sel;
  assign md_start  = bundle_q.md_start;
  assign md_op     = bundle_q.md_op;
  assign syscall   = bundle_q.syscall;
  assign illegal   = bundle_q.illegal;
  assign busy      = (state_q != ST_RUN);
  assign halted    = (state_q == ST_HALT);

endmodule
